piso_register32: RTL and testbench

PISO_REGISTER32 -- requirements
Module: piso_register32

---
 rtl/piso_register32.sv | 52 +++++
 tb/tb_piso_register32.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/piso_register32.sv
// piso_register32: 32-bit parallel-in serial-out register with ready/valid load and shift handshake
module piso_register32 #(
  parameter int MSB_FIRST = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [31:0] d,
  input  logic        shift_en,
  output logic        sout,
  output logic        sout_valid,
  output logic        done,
  output logic [5:0]  bit_cnt
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t      state, state_nx;
  logic [31:0] shreg, shreg_nx;
  logic [5:0]  cnt_nx;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
    end else begin
      state   <= state_nx;
      shreg   <= shreg_nx;
      bit_cnt <= cnt_nx;
    end
  end
  always_comb begin
    state_nx = state;
    shreg_nx = shreg;
    cnt_nx   = bit_cnt;
    if (state == IDLE && load_valid) begin
      state_nx = SHIFT;
      shreg_nx = d;
      cnt_nx   = 6'd32;
    end else if (state == SHIFT && shift_en) begin
      shreg_nx = (MSB_FIRST != 0) ? shreg << 1 : shreg >> 1;
      cnt_nx   = bit_cnt - 6'd1;
      state_nx = (bit_cnt == 6'd1) ? DONE : SHIFT;
    end else if (state != IDLE && state != SHIFT) begin
      state_nx = IDLE;
    end
  end
  // handshake outputs come from registered state only
  assign load_ready = (state == IDLE);
  assign sout_valid = (state == SHIFT);
  assign done       = (state == DONE);
  assign sout       = sout_valid & ((MSB_FIRST != 0) ? shreg[31] : shreg[0]);
endmodule

// File: tb/tb_piso_register32.sv
// tb_piso_register32: directed scoreboard bench for MSB-first and LSB-first instances
module tb_piso_register32;
  logic        clk = 0;
  logic        reset_n, load_valid, shift_en;
  logic [31:0] d;
  logic        lr_m, so_m, sv_m, dn_m, lr_l, so_l, sv_l, dn_l;
  logic [5:0]  bc_m, bc_l;
  logic        lr_o, so_o, sv_o, dn_o;
  logic [5:0]  bc_o;
  int          checks = 0, errors = 0;
  int          dn_cnt_m = 0, dn_cnt_l = 0;
  bit          use_lsb = 0;
  bit          exp_q[$];

  piso_register32 #(.MSB_FIRST(1)) dut_m (
    .clk(clk), .reset_n(reset_n), .load_valid(load_valid), .load_ready(lr_m), .d(d),
    .shift_en(shift_en), .sout(so_m), .sout_valid(sv_m), .done(dn_m), .bit_cnt(bc_m));
  piso_register32 #(.MSB_FIRST(0)) dut_l (
    .clk(clk), .reset_n(reset_n), .load_valid(load_valid), .load_ready(lr_l), .d(d),
    .shift_en(shift_en), .sout(so_l), .sout_valid(sv_l), .done(dn_l), .bit_cnt(bc_l));

  always #5 clk = ~clk;

  assign lr_o = use_lsb ? lr_l : lr_m;
  assign so_o = use_lsb ? so_l : so_m;
  assign sv_o = use_lsb ? sv_l : sv_m;
  assign dn_o = use_lsb ? dn_l : dn_m;
  assign bc_o = use_lsb ? bc_l : bc_m;

  always @(posedge clk) begin
    if (dn_m) dn_cnt_m++;
    if (dn_l) dn_cnt_l++;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  function automatic int pulses();
    return use_lsb ? dn_cnt_l : dn_cnt_m;
  endfunction

  // Transmit one word; bp toggles shift_en, lv_mid/d_mid drive load_valid/d while busy.
  task automatic xfer(input logic [31:0] w, input bit bp, input bit lv_mid,
                      input logic [31:0] d_mid, input bit lv_end);
    int acc = 0;
    int k = 0;
    int dn0 = pulses();
    check("idle_ready", lr_o, 1);
    d = w;
    load_valid = 1;
    shift_en = 0;
    for (int i = 0; i < 32; i++) exp_q.push_back(use_lsb ? w[i] : w[31-i]);
    cyc();
    load_valid = lv_mid;
    d = d_mid;
    while (acc < 32) begin
      if (k == 300) begin
        check("timeout", acc, 32);
        break;
      end
      shift_en = bp ? (k % 3 == 0) : 1'b1;
      check("busy_ready", lr_o, 0);
      check("valid", sv_o, 1);
      check("cnt", bc_o, 32 - acc);
      check("bit", so_o, exp_q[0]);
      if (shift_en) begin
        void'(exp_q.pop_front());
        acc++;
      end
      k++;
      cyc();
    end
    shift_en = 1;
    load_valid = lv_end;
    check("done", dn_o, 1);
    check("done_valid", sv_o, 0);
    check("done_ready", lr_o, 0);
    check("done_cnt", bc_o, 0);
    check("done_sout", so_o, 0);
    cyc();
    shift_en = 0;
    check("post_done", dn_o, 0);
    check("post_ready", lr_o, 1);
    check("pulses", pulses(), dn0 + 1);
  endtask

  initial begin
    int dn0;
    reset_n = 0;
    load_valid = 0;
    shift_en = 0;
    d = 0;
    cyc();
    cyc();
    reset_n = 1;
    check("rst_ready", lr_o, 1);
    check("rst_valid", sv_o, 0);
    check("rst_done", dn_o, 0);
    check("rst_sout", so_o, 0);
    check("rst_cnt", bc_o, 0);
    // MSB-first basic word
    xfer(32'h12345678, 0, 0, 32'h0, 0);
    // backpressure
    xfer(32'hffeeddcc, 1, 0, 32'h0, 0);
    // load attempts while busy are ignored
    xfer(32'hbbaabbaa, 0, 1, 32'hffffffff, 0);
    // reset mid-word, with simultaneous load and shift
    dn0 = dn_cnt_m;
    d = 32'h98765432;
    load_valid = 1;
    for (int i = 0; i < 32; i++) exp_q.push_back(d[31-i]);
    cyc();
    load_valid = 0;
    shift_en = 1;
    for (int i = 0; i < 10; i++) begin
      check("mid_bit", so_o, exp_q[0]);
      check("mid_cnt", bc_o, 32 - i);
      void'(exp_q.pop_front());
      cyc();
    end
    reset_n = 0;
    load_valid = 1;
    d = 32'hffffffff;
    cyc();
    reset_n = 1;
    load_valid = 0;
    shift_en = 0;
    exp_q.delete();
    check("mrst_ready", lr_o, 1);
    check("mrst_valid", sv_o, 0);
    check("mrst_cnt", bc_o, 0);
    check("mrst_sout", so_o, 0);
    check("mrst_done", dn_o, 0);
    cyc();
    check("mrst_pulses", dn_cnt_m, dn0);
    xfer(32'h77665544, 0, 0, 32'h0, 0);
    // back-to-back with load_valid held high
    xfer(32'h33221100, 0, 1, 32'h12345678, 1);
    xfer(32'h12345678, 0, 1, 32'h12345678, 0);
    // LSB-first instance
    use_lsb = 1;
    reset_n = 0;
    cyc();
    reset_n = 1;
    check("lsb_rst_ready", lr_o, 1);
    xfer(32'h00000001, 0, 0, 32'h0, 0);
    xfer(32'h80f0a5c3, 1, 0, 32'h0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
